sdiv_sequencer: RTL and testbench

- Request front-end for the team's 16-bit signed repeated-subtraction divider. That divider has a go/rdy handshake; rdy goes high and stays high until the next go.
- Accepts divide jobs on a valid/ready stream and buffers them in a small FIFO. Issues one go pulse per job, waits for completion, and returns tagged quotients on a valid/ready result stream.
- Short-circuits divide-by-zero, which would otherwise never terminate in the divider.

---
 rtl/sdiv_pkg.sv | 19 +
 rtl/sdiv_sequencer_if.sv | 44 ++++
 rtl/sdiv_req_fifo.sv | 51 +++++
 rtl/sdiv_sequencer.sv | 115 +++++++++++
 tb/tb_sdiv_sequencer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/sdiv_pkg.sv
// Shared types and constants for the signed-divider request sequencer.
package sdiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ARM   = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam logic [15:0] DZ_POS = 16'h7FFF;
  localparam logic [15:0] DZ_NEG = 16'h8000;

  // Saturated quotient reported for x/0, signed by the dividend.
  function automatic logic [15:0] dz_quotient(input logic [15:0] dividend);
    return dividend[15] ? DZ_NEG : DZ_POS;
  endfunction

endpackage

// File: rtl/sdiv_sequencer_if.sv
// Bundle of request, result, divider and status signals around sdiv_sequencer.
interface sdiv_sequencer_if #(
  parameter int TAG_W = 4
);
  import sdiv_pkg::*;

  // req_* and res_* are valid/ready streams: a beat transfers on a clk edge
  // where valid && ready; the producer holds payload and valid stable until then.
  logic             req_valid;
  logic             req_ready;
  logic [15:0]      req_dividend;
  logic [15:0]      req_divisor;
  logic [TAG_W-1:0] req_tag;

  logic             res_valid;
  logic             res_ready;
  logic [15:0]      res_quotient;
  logic [TAG_W-1:0] res_tag;
  logic             res_dz;

  logic             div_go;
  logic [15:0]      div_dividend;
  logic [15:0]      div_divisor;
  logic [15:0]      div_quotient;
  logic             div_rdy;

  logic             busy;
  state_t           dbg_state;

  modport slave (
    input  req_valid, req_dividend, req_divisor, req_tag,
    input  res_ready, div_quotient, div_rdy,
    output req_ready, res_valid, res_quotient, res_tag, res_dz,
    output div_go, div_dividend, div_divisor, busy, dbg_state
  );

  modport master (
    output req_valid, req_dividend, req_divisor, req_tag,
    output res_ready, div_quotient, div_rdy,
    input  req_ready, res_valid, res_quotient, res_tag, res_dz,
    input  div_go, div_dividend, div_divisor, busy, dbg_state
  );

endinterface

// File: rtl/sdiv_req_fifo.sv
// Synchronous request FIFO; count-based full/empty, power-of-two depth.
module sdiv_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sdiv_sequencer.sv
// Front-end for the 16-bit signed divider: buffers jobs, issues them one at a
// time, and returns tagged quotients; divide-by-zero is answered locally.
module sdiv_sequencer
  import sdiv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  sdiv_sequencer_if.slave bus
);

  typedef struct packed {
    logic [15:0]      dividend;
    logic [15:0]      divisor;
    logic [TAG_W-1:0] tag;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  req_t             push_data;
  req_t             head;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             res_free;

  state_t           state_q;
  req_t             op_q;
  logic             res_valid_q;
  logic [15:0]      res_quotient_q;
  logic [TAG_W-1:0] res_tag_q;
  logic             res_dz_q;
  logic             div_go_q;

  assign push_data = '{dividend: bus.req_dividend, divisor: bus.req_divisor, tag: bus.req_tag};
  assign push      = bus.req_valid && !full;
  assign res_free  = !res_valid_q || bus.res_ready;
  assign pop       = (state_q == IDLE) && !empty && res_free;

  sdiv_req_fifo #(
    .DEPTH (DEPTH),
    .W     (REQ_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // ARM exists because the divider's rdy is sticky: it is still high from the
  // previous job when go is issued and must be seen low before it means done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      op_q           <= '0;
      res_valid_q    <= 1'b0;
      res_quotient_q <= '0;
      res_tag_q      <= '0;
      res_dz_q       <= 1'b0;
      div_go_q       <= 1'b0;
    end else begin
      div_go_q <= 1'b0;
      if (res_valid_q && bus.res_ready) res_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            op_q <= head;
            if (head.divisor == '0) begin
              res_valid_q    <= 1'b1;
              res_quotient_q <= dz_quotient(head.dividend);
              res_tag_q      <= head.tag;
              res_dz_q       <= 1'b1;
            end else begin
              state_q  <= ISSUE;
              div_go_q <= 1'b1;
            end
          end
        end
        ISSUE: state_q <= ARM;
        ARM: begin
          if (!bus.div_rdy) state_q <= WAIT;
        end
        WAIT: begin
          if (bus.div_rdy) begin
            res_valid_q    <= 1'b1;
            res_quotient_q <= bus.div_quotient;
            res_tag_q      <= op_q.tag;
            res_dz_q       <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = !full;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_quotient = res_quotient_q;
  assign bus.res_tag      = res_tag_q;
  assign bus.res_dz       = res_dz_q;
  assign bus.div_go       = div_go_q;
  assign bus.div_dividend = op_q.dividend;
  assign bus.div_divisor  = op_q.divisor;
  assign bus.busy         = (state_q != IDLE) || !empty;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_sdiv_sequencer.sv
// Scoreboard bench for sdiv_sequencer with a behavioural sticky-rdy divider.
module tb_sdiv_sequencer;
  import sdiv_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int RW    = 16 + TAG_W + 1;

  logic clk;
  logic rst_n;

  sdiv_sequencer_if #(.TAG_W(TAG_W)) bus ();

  sdiv_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int go_cnt   = 0;
  int epoch    = 0;
  int stale_cycles = 0;
  logic [RW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- divider model ----------------
  logic signed [15:0] m_a;
  logic signed [15:0] m_b;
  int m_lat;
  int m_epoch;

  always begin
    @(negedge clk);
    if (rst_n && bus.div_go) begin
      m_a = bus.div_dividend;
      m_b = bus.div_divisor;
      m_epoch = epoch;
      repeat (stale_cycles) @(posedge clk);
      @(posedge clk);
      #1 bus.div_rdy = 1'b0;
      m_lat = $urandom_range(3, 40);
      repeat (m_lat) @(posedge clk);
      #1;
      if (m_epoch == epoch) begin
        bus.div_quotient = m_a / m_b;
        bus.div_rdy = 1'b1;
      end
    end
  end

  always @(negedge clk) if (rst_n && bus.div_go) go_cnt++;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {11'd0, bus.res_quotient, bus.res_tag, bus.res_dz}, 32'hFFFF_FFFF);
      end else begin
        check("result", {11'd0, bus.res_quotient, bus.res_tag, bus.res_dz}, {11'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a posedge; returns just after the accepting posedge.
  task automatic push_job(input logic [15:0] a, input logic [15:0] b, input logic [TAG_W-1:0] tag,
                          input logic [15:0] q, input logic dz);
    bit ok;
    ok = 1'b0;
    bus.req_valid    = 1'b1;
    bus.req_dividend = a;
    bus.req_divisor  = b;
    bus.req_tag      = tag;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        exp_q.push_back({q, tag, dz});
        ok = 1'b1;
        break;
      end
    end
    check("push_accept", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check(name, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_res_valid"}, {31'd0, bus.res_valid}, 32'd0);
    check({tag, "_res_quotient"}, {16'd0, bus.res_quotient}, 32'd0);
    check({tag, "_div_go"}, {31'd0, bus.div_go}, 32'd0);
    check({tag, "_div_operands"}, {bus.div_dividend, bus.div_divisor}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_state"}, {30'd0, bus.dbg_state}, {30'd0, IDLE});
    check({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int g0;
  bit stuck;

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_dividend = '0;
    bus.req_divisor = '0;
    bus.req_tag = '0;
    bus.res_ready = 1'b1;
    bus.div_quotient = '0;
    bus.div_rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single job
    g0 = go_cnt;
    push_job(16'd100, 16'd7, 4'd3, 16'd14, 1'b0);
    drain("single_drain");
    check("single_go_count", go_cnt - g0, 1);

    // sign cases
    push_job(-16'sd100, 16'd7, 4'd4, 16'hFFF2, 1'b0);
    push_job(16'd100, -16'sd7, 4'd5, 16'hFFF2, 1'b0);
    push_job(-16'sd100, -16'sd7, 4'd6, 16'd14, 1'b0);
    drain("sign_drain");

    // divide by zero: no go, result after the second edge
    g0 = go_cnt;
    push_job(16'd5, 16'd0, 4'd7, 16'h7FFF, 1'b1);
    @(negedge clk);
    check("dz_not_early", {31'd0, bus.res_valid}, 32'd0);
    @(negedge clk);
    check("dz_latency", {31'd0, bus.res_valid}, 32'd1);
    @(posedge clk);
    #1;
    push_job(-16'sd5, 16'd0, 4'd8, 16'h8000, 1'b1);
    drain("dz_drain");
    check("dz_go_count", go_cnt - g0, 0);

    // back-pressure: DEPTH in the FIFO plus one in the result register
    bus.res_ready = 1'b0;
    push_job(16'd50, 16'd7, 4'd0, 16'd7, 1'b0);
    push_job(-16'sd50, 16'd7, 4'd1, 16'hFFF9, 1'b0);
    push_job(16'd77, -16'sd11, 4'd2, 16'hFFF9, 1'b0);
    push_job(16'd32767, 16'd2, 4'd3, 16'h3FFF, 1'b0);
    push_job(16'h8000, 16'd3, 4'd4, 16'hD556, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_dividend = 16'd9;
    bus.req_divisor = 16'd0;
    bus.req_tag = 4'd5;
    stuck = 1'b1;
    repeat (120) begin
      @(negedge clk);
      if (bus.req_ready) stuck = 1'b0;
    end
    check("full_blocks", {31'd0, stuck}, 32'd1);
    check("full_res_valid", {31'd0, bus.res_valid}, 32'd1);
    check("full_busy", {31'd0, bus.busy}, 32'd1);
    @(posedge clk);
    #1 bus.res_ready = 1'b1;
    push_job(16'd9, 16'd0, 4'd5, 16'h7FFF, 1'b1);
    drain("full_drain");

    // stale rdy held after go
    stale_cycles = 2;
    push_job(16'd1000, 16'd3, 4'd9, 16'h014D, 1'b0);
    drain("stale_drain");
    stale_cycles = 0;

    // reset during WAIT with a second job queued
    push_job(16'd200, 16'd9, 4'd10, 16'd22, 1'b0);
    push_job(16'd300, 16'd9, 4'd11, 16'd33, 1'b0);
    stuck = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.dbg_state == WAIT) begin
        stuck = 1'b0;
        break;
      end
    end
    check("reach_wait", {31'd0, stuck}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    epoch++;
    exp_q.delete();
    @(negedge clk);
    check_idle_outputs("midreset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    @(negedge clk);
    check("post_reset_quiet", {31'd0, bus.res_valid}, 32'd0);
    @(posedge clk);
    #1;
    push_job(-16'sd7, 16'd2, 4'd12, 16'hFFFD, 1'b0);
    drain("post_reset_drain");
    check("final_busy", {31'd0, bus.busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
